// File: rtl/uart_frame_decoder_pkg.sv
// Shared constants and FSM encoding for the UART frame decoder.
// The default timeout allows four byte times at 115200 baud on a 200 MHz clock.
package uart_frame_decoder_pkg;

    localparam logic [7:0] SYNC_DEFAULT   = 8'hA5;
    localparam int         CLK_HZ         = 200_000_000;
    localparam int         BAUD           = 115_200;
    localparam int         BITDUR         = CLK_HZ / BAUD;
    localparam int         BYTE_TIME      = 10 * BITDUR;
    localparam int         TIMEOUT_DEFAULT = 4 * BYTE_TIME;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

endpackage

// File: rtl/uart_frame_decoder_inter_byte_timer.sv
// Idle-cycle counter between received bytes; expires after TIMEOUT quiet cycles.
// A clear on the terminal cycle wins, so a byte arriving just in time never times out.
module inter_byte_timer #(
    parameter int TIMEOUT = 69440
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int              CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    assign o_expire = i_enable && !i_clear && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset || i_clear || !i_enable || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_decoder.sv
// Assembles SYNC + payload + XOR-checksum frames from a UART byte strobe stream
// and presents good payloads on a held valid/ack interface with error pulses.
module uart_frame_decoder
    import uart_frame_decoder_pkg::*;
#(
    parameter int         WORDBYTES = 4,
    parameter logic [7:0] SYNC      = SYNC_DEFAULT,
    parameter int         TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_ready,
    output logic [8*WORDBYTES-1:0] word,
    output logic                   word_valid,
    input  logic                   word_ack,
    output logic                   err_chk,
    output logic                   err_timeout,
    output logic                   err_overflow,
    output state_t                 dbg_state
);

    localparam int W   = 8 * WORDBYTES;
    localparam int BCW = $clog2(WORDBYTES + 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(WORDBYTES - 1);

    state_t         r_state, w_state_nxt;
    logic [BCW-1:0] r_bcnt, w_bcnt_nxt;
    logic [W-1:0]   r_asm, w_asm_nxt;
    logic [7:0]     r_chk, w_chk_nxt;
    logic [W-1:0]   r_word, w_word_nxt;
    logic           r_word_valid, w_valid_nxt;
    logic           r_err_chk, w_err_chk_nxt;
    logic           r_err_to, w_err_to_nxt;
    logic           r_err_ovf, w_err_ovf_nxt;
    logic           w_tmr_en;
    logic           w_expire;

    inter_byte_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (rx_ready),
        .i_enable (w_tmr_en),
        .o_expire (w_expire)
    );

    assign w_tmr_en = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt   = r_state;
        w_bcnt_nxt    = r_bcnt;
        w_asm_nxt     = r_asm;
        w_chk_nxt     = r_chk;
        w_word_nxt    = r_word;
        // An ack retires the pending word; a good frame this cycle may reload it below.
        w_valid_nxt   = r_word_valid && !word_ack;
        w_err_chk_nxt = 1'b0;
        w_err_to_nxt  = 1'b0;
        w_err_ovf_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_ready && rx_data == SYNC) begin
                    w_state_nxt = ST_PAYLOAD;
                    w_bcnt_nxt  = '0;
                    w_chk_nxt   = '0;
                    w_asm_nxt   = '0;
                end
            end
            ST_PAYLOAD: begin
                if (rx_ready) begin
                    w_asm_nxt = {r_asm[W-9:0], rx_data};
                    w_chk_nxt = r_chk ^ rx_data;
                    if (r_bcnt == LAST_BYTE) begin
                        w_state_nxt = ST_CHECK;
                        w_bcnt_nxt  = '0;
                    end else begin
                        w_bcnt_nxt  = r_bcnt + 1'b1;
                    end
                end else if (w_expire) begin
                    w_state_nxt  = ST_IDLE;
                    w_bcnt_nxt   = '0;
                    w_err_to_nxt = 1'b1;
                end
            end
            ST_CHECK: begin
                if (rx_ready) begin
                    w_state_nxt = ST_IDLE;
                    if (rx_data == r_chk) begin
                        if (!r_word_valid || word_ack) begin
                            w_word_nxt  = r_asm;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_err_ovf_nxt = 1'b1;
                        end
                    end else begin
                        w_err_chk_nxt = 1'b1;
                    end
                end else if (w_expire) begin
                    w_state_nxt  = ST_IDLE;
                    w_err_to_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_bcnt       <= '0;
            r_asm        <= '0;
            r_chk        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_err_chk    <= 1'b0;
            r_err_to     <= 1'b0;
            r_err_ovf    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_asm        <= w_asm_nxt;
            r_chk        <= w_chk_nxt;
            r_word       <= w_word_nxt;
            r_word_valid <= w_valid_nxt;
            r_err_chk    <= w_err_chk_nxt;
            r_err_to     <= w_err_to_nxt;
            r_err_ovf    <= w_err_ovf_nxt;
        end
    end

    assign word         = r_word;
    assign word_valid   = r_word_valid;
    assign err_chk      = r_err_chk;
    assign err_timeout  = r_err_to;
    assign err_overflow = r_err_ovf;
    assign dbg_state    = r_state;

endmodule
